// File: rtl/tlb_op_ctrl.sv
// Purpose: sequencer for the TLB maintenance ops (TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB)
//          driving the 16-entry dual-port TLB array's read, write and search-port-1 controls.
// Latency: SRCH/RD/WR/FILL done 2 cycles after accept, INVTLB TLBNUM+1, illegal op 1.
// Backpressure: op_ready high only in IDLE; op_valid while busy is ignored and must be held.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   op_valid/op_ready     instruction handshake; op_code, inv_op, inv_asid, inv_vppn, csr_index latched on accept
//   srch_req              steals search port 1 for TLBSRCH; srch_found/srch_index are its results
//   tlb_r_index, tlb_r_*  array read index and read-back fields (E, G, ASID, VPPN, PS)
//   tlb_we, tlb_w_index   array write strobe/index; tlb_w_sel=0 writes CSR fields, 1 rewrites read-back with E=0
//   busy, done, done_*    status and one-cycle completion pulse with result; err_ine flags an illegal op
//
// Optional build macro TLB_FILL_LFSR_EN: fill index taken from an 8-bit Fibonacci LFSR
// (taps 8,6,5,4, seed 8'h01) instead of a free-running wrapping counter.

module tlb_op_ctrl #(
  parameter  int TLBNUM = 16,
  localparam int IDXW   = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [2:0]      op_code,
  input  logic [4:0]      inv_op,
  input  logic [9:0]      inv_asid,
  input  logic [18:0]     inv_vppn,
  input  logic [IDXW-1:0] csr_index,
  output logic            srch_req,
  input  logic            srch_found,
  input  logic [IDXW-1:0] srch_index,
  output logic [IDXW-1:0] tlb_r_index,
  input  logic            tlb_r_e,
  input  logic            tlb_r_g,
  input  logic [9:0]      tlb_r_asid,
  input  logic [18:0]     tlb_r_vppn,
  input  logic [5:0]      tlb_r_ps,
  output logic            tlb_we,
  output logic [IDXW-1:0] tlb_w_index,
  output logic            tlb_w_sel,
  output logic            busy,
  output logic            done,
  output logic [2:0]      done_op,
  output logic            done_found,
  output logic [IDXW-1:0] done_index,
  output logic            err_ine
);

  typedef enum logic [2:0] {
    S_IDLE, S_SRCH, S_RD, S_WR, S_FILL, S_WALK, S_DONE
  } state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(TLBNUM - 1);

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [4:0]      inv_op_q, inv_op_d;
  logic [9:0]      inv_asid_q, inv_asid_d;
  logic [18:0]     inv_vppn_q, inv_vppn_d;
  logic [IDXW-1:0] csr_idx_q, csr_idx_d;
  logic [IDXW-1:0] walk_q, walk_d;
  logic            res_found_q, res_found_d;
  logic [IDXW-1:0] res_idx_q, res_idx_d;
  logic            err_q, err_d;
  logic [IDXW-1:0] fill_idx;

`ifdef TLB_FILL_LFSR_EN
  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;
  assign lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign fill_idx = lfsr_q[IDXW-1:0];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= 8'h01;
    else       lfsr_q <= lfsr_d;
  end
`else
  logic [IDXW-1:0] fill_ctr_q;
  logic [IDXW-1:0] fill_ctr_d;
  assign fill_ctr_d = fill_ctr_q + 1'b1;  // wraps naturally at TLBNUM
  assign fill_idx   = fill_ctr_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) fill_ctr_q <= '0;
    else       fill_ctr_q <= fill_ctr_d;
  end
`endif

  // INVTLB match against the entry currently presented on the read port.
  // A 2MB page (ps=21) ignores VPPN[9:0].
  logic va_match, asid_match, inv_cond, inv_hit;
  always_comb begin
    va_match   = (tlb_r_vppn[18:10] == inv_vppn_q[18:10]) &&
                 ((tlb_r_ps == 6'd21) || (tlb_r_vppn[9:0] == inv_vppn_q[9:0]));
    asid_match = (tlb_r_asid == inv_asid_q);
    case (inv_op_q)
      5'd0, 5'd1: inv_cond = 1'b1;
      5'd2:       inv_cond = tlb_r_g;
      5'd3:       inv_cond = !tlb_r_g;
      5'd4:       inv_cond = !tlb_r_g && asid_match;
      5'd5:       inv_cond = !tlb_r_g && asid_match && va_match;
      5'd6:       inv_cond = (tlb_r_g || asid_match) && va_match;
      default:    inv_cond = 1'b0;
    endcase
    inv_hit = tlb_r_e && inv_cond;
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    inv_op_d    = inv_op_q;
    inv_asid_d  = inv_asid_q;
    inv_vppn_d  = inv_vppn_q;
    csr_idx_d   = csr_idx_q;
    walk_d      = walk_q;
    res_found_d = res_found_q;
    res_idx_d   = res_idx_q;
    err_d       = err_q;

    op_ready    = 1'b0;
    srch_req    = 1'b0;
    tlb_r_index = '0;
    tlb_we      = 1'b0;
    tlb_w_index = '0;
    tlb_w_sel   = 1'b0;
    busy        = (state_q != S_IDLE);
    done        = 1'b0;
    done_op     = 3'd0;
    done_found  = 1'b0;
    done_index  = '0;
    err_ine     = 1'b0;

    case (state_q)
      S_IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          op_d        = op_code;
          inv_op_d    = inv_op;
          inv_asid_d  = inv_asid;
          inv_vppn_d  = inv_vppn;
          csr_idx_d   = csr_index;
          walk_d      = '0;
          res_found_d = 1'b0;
          res_idx_d   = '0;
          err_d       = 1'b0;
          case (op_code)
            3'd0: state_d = S_SRCH;
            3'd1: state_d = S_RD;
            3'd2: state_d = S_WR;
            3'd3: state_d = S_FILL;
            3'd4: begin
              if (inv_op <= 5'd6) begin
                state_d = S_WALK;
              end else begin
                state_d = S_DONE;
                err_d   = 1'b1;
              end
            end
            default: begin
              state_d = S_DONE;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      S_SRCH: begin
        srch_req    = 1'b1;
        res_found_d = srch_found;
        res_idx_d   = srch_index;
        state_d     = S_DONE;
      end
      S_RD: begin
        tlb_r_index = csr_idx_q;
        state_d     = S_DONE;
      end
      S_WR: begin
        tlb_we      = 1'b1;
        tlb_w_index = csr_idx_q;
        res_idx_d   = csr_idx_q;
        state_d     = S_DONE;
      end
      S_FILL: begin
        tlb_we      = 1'b1;
        tlb_w_index = fill_idx;
        res_idx_d   = fill_idx;
        state_d     = S_DONE;
      end
      S_WALK: begin
        // Read and conditional write-back of the same entry happen in one cycle.
        tlb_r_index = walk_q;
        if (inv_hit) begin
          tlb_we      = 1'b1;
          tlb_w_index = walk_q;
          tlb_w_sel   = 1'b1;
        end
        walk_d = walk_q + 1'b1;
        if (walk_q == LAST_IDX) state_d = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        done_op    = op_q;
        done_found = res_found_q;
        done_index = res_idx_q;
        err_ine    = err_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= 3'd0;
      inv_op_q    <= 5'd0;
      inv_asid_q  <= 10'd0;
      inv_vppn_q  <= 19'd0;
      csr_idx_q   <= '0;
      walk_q      <= '0;
      res_found_q <= 1'b0;
      res_idx_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      inv_op_q    <= inv_op_d;
      inv_asid_q  <= inv_asid_d;
      inv_vppn_q  <= inv_vppn_d;
      csr_idx_q   <= csr_idx_d;
      walk_q      <= walk_d;
      res_found_q <= res_found_d;
      res_idx_q   <= res_idx_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Bench for tlb_op_ctrl: behavioural 16-entry TLB array, table-driven single-op vectors,
// table-driven INVTLB walks over a fixed preload, FILL index tracking and reset mid-walk.
module tb_tlb_op_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic        op_ready;
  logic [2:0]  op_code;
  logic [4:0]  inv_op;
  logic [9:0]  inv_asid;
  logic [18:0] inv_vppn;
  logic [3:0]  csr_index;
  logic        srch_req;
  logic        srch_found;
  logic [3:0]  srch_index;
  logic [3:0]  tlb_r_index;
  logic        tlb_r_e, tlb_r_g;
  logic [9:0]  tlb_r_asid;
  logic [18:0] tlb_r_vppn;
  logic [5:0]  tlb_r_ps;
  logic        tlb_we;
  logic [3:0]  tlb_w_index;
  logic        tlb_w_sel;
  logic        busy, done;
  logic [2:0]  done_op;
  logic        done_found;
  logic [3:0]  done_index;
  logic        err_ine;

  always #5 clk = ~clk;

  tlb_op_ctrl dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn),
    .csr_index(csr_index), .srch_req(srch_req), .srch_found(srch_found),
    .srch_index(srch_index), .tlb_r_index(tlb_r_index), .tlb_r_e(tlb_r_e),
    .tlb_r_g(tlb_r_g), .tlb_r_asid(tlb_r_asid), .tlb_r_vppn(tlb_r_vppn),
    .tlb_r_ps(tlb_r_ps), .tlb_we(tlb_we), .tlb_w_index(tlb_w_index),
    .tlb_w_sel(tlb_w_sel), .busy(busy), .done(done), .done_op(done_op),
    .done_found(done_found), .done_index(done_index), .err_ine(err_ine)
  );

  // Behavioural TLB array
  typedef struct packed {
    logic        e;
    logic        g;
    logic [9:0]  asid;
    logic [18:0] vppn;
    logic [5:0]  ps;
  } ent_t;
  ent_t mem [16];

  assign tlb_r_e    = mem[tlb_r_index].e;
  assign tlb_r_g    = mem[tlb_r_index].g;
  assign tlb_r_asid = mem[tlb_r_index].asid;
  assign tlb_r_vppn = mem[tlb_r_index].vppn;
  assign tlb_r_ps   = mem[tlb_r_index].ps;

  // Cycles since reset release: the expected default fill index modulo 16.
  int cyc;
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Results of the last run_op
  int          r_lat, r_we, r_srch, r_sel1, r_order_err, r_fill_exp, r_ridx_first;
  logic [15:0] r_wmask;
  int          r_last_widx, r_last_sel;
  logic        r_done_found, r_err, r_rdy_k1, r_rdy_after, r_done_after, r_rst;
  int          r_done_idx, r_done_op;

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = '{e:1'b0, g:1'b0, asid:10'd0, vppn:19'd0, ps:6'd12};
  endtask

  task automatic preload_std(input logic [5:0] ps7);
    clear_mem();
    mem[2]  = '{e:1'b1, g:1'b1, asid:10'h005, vppn:19'h11111, ps:6'd12};
    mem[7]  = '{e:1'b1, g:1'b0, asid:10'h012, vppn:19'h2A5C3, ps:ps7};
    mem[11] = '{e:1'b0, g:1'b0, asid:10'h012, vppn:19'h2A5C3, ps:6'd12};
    mem[13] = '{e:1'b1, g:1'b0, asid:10'h012, vppn:19'h2A5C2, ps:6'd12};
    mem[14] = '{e:1'b1, g:1'b0, asid:10'h033, vppn:19'h2A5C3, ps:6'd12};
  endtask

  // Issue one op, follow it to done (or to a reset injected at cycle rst_at after accept).
  task automatic run_op(input logic [2:0] opc, input logic [4:0] iop, input logic [9:0] asid,
                        input logic [18:0] vppn, input logic [3:0] cidx, input logic sf,
                        input logic [3:0] si, input int rst_at);
    logic       pend, psel;
    logic [3:0] pidx;
    r_lat = 0; r_we = 0; r_srch = 0; r_sel1 = 0; r_order_err = 0; r_wmask = '0;
    r_last_widx = -1; r_last_sel = -1; r_rst = 1'b0; r_fill_exp = -1; r_ridx_first = -1;
    r_rdy_k1 = 1'b1; r_rdy_after = 1'b0; r_done_after = 1'b1;
    @(negedge clk);
    op_valid = 1'b1; op_code = opc; inv_op = iop; inv_asid = asid; inv_vppn = vppn;
    csr_index = cidx; srch_found = sf; srch_index = si;
    chk("accept ready", int'(op_ready), 1);
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (rst_at == k) begin
        reset = 1'b1;
        r_rst = 1'b1;
        break;
      end
      if (k == 1) begin
        r_ridx_first = int'(tlb_r_index);
        r_fill_exp   = cyc % 16;
        r_rdy_k1     = op_ready;
      end
      if (opc == 3'd4 && k <= 16 && !done && int'(tlb_r_index) != k - 1) r_order_err++;
      if (srch_req) r_srch++;
      pend = 1'b0; psel = 1'b0; pidx = '0;
      if (tlb_we) begin
        r_we++;
        r_last_widx = int'(tlb_w_index);
        r_last_sel  = int'(tlb_w_sel);
        if (tlb_w_sel) r_sel1++;
        r_wmask[tlb_w_index] = 1'b1;
        pend = 1'b1; psel = tlb_w_sel; pidx = tlb_w_index;
      end
      if (done) begin
        r_lat = k; r_done_op = int'(done_op); r_done_found = done_found;
        r_done_idx = int'(done_index); r_err = err_ine;
        break;
      end
      @(posedge clk);
      if (pend) begin
        if (psel) mem[pidx].e = 1'b0;
        else      mem[pidx] = '{e:1'b1, g:1'b0, asid:10'd0, vppn:19'd0, ps:6'd12};
      end
      @(negedge clk);
    end
    if (!r_rst) begin
      if (r_lat == 0) chk("done timeout", 0, 1);
      @(negedge clk);
      r_rdy_after  = op_ready;
      r_done_after = done;
    end
  endtask

  typedef struct {
    logic [2:0] opc;
    logic [4:0] iop;
    logic [3:0] cidx;
    logic       sf;
    logic [3:0] si;
    int         exp_lat;
    int         exp_we;
    int         exp_srch;
    logic       exp_err;
    logic       exp_found;
    int         exp_idx;   // -1: not checked
    int         exp_ridx;  // -1: not checked
  } vec_t;

  typedef struct {
    logic [4:0]  iop;
    logic [9:0]  asid;
    logic [18:0] vppn;
    logic [5:0]  ps7;
    logic [15:0] exp_mask;
  } inv_vec_t;

  vec_t     vecs [11];
  inv_vec_t ivecs [11];

  initial begin
    vecs[0]  = '{3'd2, 5'd0, 4'd5,  1'b0, 4'd0, 2, 1, 0, 1'b0, 1'b0, 5,  -1};
    vecs[1]  = '{3'd0, 5'd0, 4'd0,  1'b1, 4'd9, 2, 0, 1, 1'b0, 1'b1, 9,  -1};
    vecs[2]  = '{3'd0, 5'd0, 4'd0,  1'b0, 4'd3, 2, 0, 1, 1'b0, 1'b0, 3,  -1};
    vecs[3]  = '{3'd1, 5'd0, 4'd12, 1'b0, 4'd0, 2, 0, 0, 1'b0, 1'b0, -1, 12};
    vecs[4]  = '{3'd6, 5'd0, 4'd3,  1'b0, 4'd0, 1, 0, 0, 1'b1, 1'b0, -1, -1};
    vecs[5]  = '{3'd7, 5'd0, 4'd3,  1'b0, 4'd0, 1, 0, 0, 1'b1, 1'b0, -1, -1};
    vecs[6]  = '{3'd5, 5'd0, 4'd3,  1'b0, 4'd0, 1, 0, 0, 1'b1, 1'b0, -1, -1};
    vecs[7]  = '{3'd4, 5'd9, 4'd0,  1'b0, 4'd0, 1, 0, 0, 1'b1, 1'b0, -1, -1};
    vecs[8]  = '{3'd4, 5'd7, 4'd0,  1'b0, 4'd0, 1, 0, 0, 1'b1, 1'b0, -1, -1};
    vecs[9]  = '{3'd2, 5'd0, 4'd15, 1'b0, 4'd0, 2, 1, 0, 1'b0, 1'b0, 15, -1};
    vecs[10] = '{3'd2, 5'd0, 4'd0,  1'b0, 4'd0, 2, 1, 0, 1'b0, 1'b0, 0,  -1};

    // Preload: 2 G valid, 7 nonG asid12 V2, 11 invalid, 13 nonG asid12 V2^1, 14 nonG asid33 V2
    ivecs[0]  = '{5'd0, 10'h000, 19'h00000, 6'd21, 16'h6084};
    ivecs[1]  = '{5'd1, 10'h000, 19'h00000, 6'd21, 16'h6084};
    ivecs[2]  = '{5'd2, 10'h000, 19'h00000, 6'd21, 16'h0004};
    ivecs[3]  = '{5'd3, 10'h000, 19'h00000, 6'd21, 16'h6080};
    ivecs[4]  = '{5'd4, 10'h012, 19'h00000, 6'd21, 16'h2080};
    ivecs[5]  = '{5'd5, 10'h012, 19'h2A5C3, 6'd21, 16'h0080};
    ivecs[6]  = '{5'd5, 10'h012, 19'h2A63C, 6'd21, 16'h0080};
    ivecs[7]  = '{5'd5, 10'h012, 19'h2A63C, 6'd12, 16'h0000};
    ivecs[8]  = '{5'd5, 10'h012, 19'h2A5C2, 6'd21, 16'h2080};
    ivecs[9]  = '{5'd6, 10'h005, 19'h11111, 6'd21, 16'h0004};
    ivecs[10] = '{5'd6, 10'h033, 19'h2A5C3, 6'd21, 16'h4000};

    reset = 1'b1; op_valid = 1'b0; op_code = '0; inv_op = '0; inv_asid = '0; inv_vppn = '0;
    csr_index = '0; srch_found = 1'b0; srch_index = '0;
    clear_mem();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst op_ready", int'(op_ready), 1);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst tlb_we", int'(tlb_we), 0);
    chk("rst srch_req", int'(srch_req), 0);
    chk("rst err_ine", int'(err_ine), 0);
    chk("rst tlb_r_index", int'(tlb_r_index), 0);
    reset = 1'b0;

    // Single-op vectors
    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].opc, vecs[i].iop, 10'd0, 19'd0, vecs[i].cidx, vecs[i].sf, vecs[i].si, -1);
      chk($sformatf("v%0d latency", i), r_lat, vecs[i].exp_lat);
      chk($sformatf("v%0d we count", i), r_we, vecs[i].exp_we);
      chk($sformatf("v%0d srch_req count", i), r_srch, vecs[i].exp_srch);
      chk($sformatf("v%0d err_ine", i), int'(r_err), int'(vecs[i].exp_err));
      chk($sformatf("v%0d done_found", i), int'(r_done_found), int'(vecs[i].exp_found));
      chk($sformatf("v%0d done_op", i), r_done_op, int'(vecs[i].opc));
      if (vecs[i].exp_idx >= 0) chk($sformatf("v%0d done_index", i), r_done_idx, vecs[i].exp_idx);
      if (vecs[i].exp_ridx >= 0) chk($sformatf("v%0d r_index", i), r_ridx_first, vecs[i].exp_ridx);
      if (vecs[i].exp_we > 0) begin
        chk($sformatf("v%0d w_index", i), r_last_widx, vecs[i].exp_idx);
        chk($sformatf("v%0d w_sel", i), r_last_sel, 0);
      end
      chk($sformatf("v%0d ready after accept", i), int'(r_rdy_k1), 0);
      chk($sformatf("v%0d ready after done", i), int'(r_rdy_after), 1);
      chk($sformatf("v%0d done pulse width", i), int'(r_done_after), 0);
    end

    // FILL: index follows the free-running counter
    for (int j = 0; j < 3; j++) begin
      repeat (j + 1) @(negedge clk);
      run_op(3'd3, 5'd0, 10'd0, 19'd0, 4'd0, 1'b0, 4'd0, -1);
      chk($sformatf("fill%0d latency", j), r_lat, 2);
      chk($sformatf("fill%0d we count", j), r_we, 1);
      chk($sformatf("fill%0d w_index", j), r_last_widx, r_fill_exp);
      chk($sformatf("fill%0d w_sel", j), r_last_sel, 0);
      chk($sformatf("fill%0d done_index", j), r_done_idx, r_fill_exp);
    end

    // INVTLB walks
    for (int i = 0; i < 11; i++) begin
      preload_std(ivecs[i].ps7);
      run_op(3'd4, ivecs[i].iop, ivecs[i].asid, ivecs[i].vppn, 4'd0, 1'b0, 4'd0, -1);
      chk($sformatf("inv%0d latency", i), r_lat, 17);
      chk($sformatf("inv%0d write mask", i), int'(r_wmask), int'(ivecs[i].exp_mask));
      chk($sformatf("inv%0d w_sel ones", i), r_sel1, r_we);
      chk($sformatf("inv%0d walk order errors", i), r_order_err, 0);
      chk($sformatf("inv%0d err_ine", i), int'(r_err), 0);
      chk($sformatf("inv%0d done_op", i), r_done_op, 4);
    end

    // Reset during the walk at i=4
    clear_mem();
    for (int i = 0; i < 16; i++) mem[i].e = 1'b1;
    run_op(3'd4, 5'd0, 10'd0, 19'd0, 4'd0, 1'b0, 4'd0, 5);
    chk("midrst reached", int'(r_rst), 1);
    #1;
    chk("midrst op_ready", int'(op_ready), 1);
    chk("midrst busy", int'(busy), 0);
    chk("midrst tlb_we", int'(tlb_we), 0);
    chk("midrst done", int'(done), 0);
    chk("midrst tlb_r_index", int'(tlb_r_index), 0);
    @(posedge clk);
    @(negedge clk);
    chk("midrst tlb_we held", int'(tlb_we), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst write mask", int'(r_wmask), 16'h000F);
    begin
      int nvalid = 0;
      for (int i = 0; i < 16; i++) if (mem[i].e) nvalid++;
      chk("midrst untouched entries", nvalid, 12);
    end
    chk("midrst idle ready", int'(op_ready), 1);
    chk("midrst idle busy", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
